// File: rtl/alu64_block_if.sv
// alu64_block operand/select/result bundle.
// master drives operands and select, slave returns the result.
interface alu64_block_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             S0;
  logic             S1;
  logic [WIDTH:0]   Final_Output;

  modport master (
    output Ain,
    output Bin,
    output S0,
    output S1,
    input  Final_Output
  );

  modport slave (
    input  Ain,
    input  Bin,
    input  S0,
    input  S1,
    output Final_Output
  );
endinterface

// File: rtl/alu64_block.sv
// Y86-64 execute ALU: ADD/SUB/AND/XOR with signed overflow.
// One registered result per cycle, async active-low reset.
module alu64_block #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  alu64_block_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [1:0]       sel;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cy;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] xor_v;
  logic             ovf;
  logic [WIDTH:0]   final_d;
  logic [WIDTH:0]   final_q;

  assign sel   = {bus.S1, bus.S0};
  assign sub   = (sel == OP_SUB);
  assign a     = bus.Ain;
  assign b     = bus.Bin;
  assign b_eff = sub ? ~b : b;
  assign cy[0] = sub;

  // Ripple adder shared by ADD and SUB (SUB = A + ~B + 1).
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_eff[i] ^ cy[i];
    assign and_v[i] = a[i] & b[i];
    assign xor_v[i] = a[i] ^ b[i];
    if (i < WIDTH - 1) begin : g_cy
      assign cy[i+1] = (a[i] & b_eff[i])
                     | (cy[i] & (a[i] ^ b_eff[i]));
    end
  end

  // Signed overflow: adder inputs agree in sign, result does not.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1])
             & (sum[WIDTH-1] != a[WIDTH-1]);

  // Result mux; overflow only meaningful for arithmetic.
  always_comb begin
    final_d = '0;
    case (sel)
      OP_ADD:  final_d = {ovf, sum};
      OP_SUB:  final_d = {ovf, sum};
      OP_AND:  final_d = {1'b0, and_v};
      OP_XOR:  final_d = {1'b0, xor_v};
      default: final_d = '0;
    endcase
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) final_q <= '0;
    else        final_q <= final_d;
  end

  assign bus.Final_Output = final_q;

endmodule

// File: tb/tb_alu64_block.sv
// Directed-vector, sequence and random checks
// for alu64_block.
module tb_alu64_block;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  s;
    logic [64:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  alu64_block_if #(.WIDTH(64)) bus ();

  alu64_block #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [64:0] act,
                       input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [1:0]  s);
    bus.Ain = a;
    bus.Bin = b;
    bus.S1  = s[1];
    bus.S0  = s[0];
  endtask

  function automatic logic [64:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic [1:0]  s);
    logic [63:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (s)
      2'b00: begin
        r = a + b;
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      2'b01: begin
        r = a - b;
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    return {v, r};
  endfunction

  vec_t vecs[13];

  initial begin
    logic [64:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [1:0]  rs;
    logic [64:0] bb_exp[4];
    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{"add_5_7",    64'd5, 64'd7, 2'b00, 65'h0_000000000000000C};
    vecs[1]  = '{"add_m1_1",   64'hFFFFFFFFFFFFFFFF, 64'd1, 2'b00, 65'h0};
    vecs[2]  = '{"add_maxp1",  64'h7FFFFFFFFFFFFFFF, 64'd1, 2'b00,
                 65'h1_8000000000000000};
    vecs[3]  = '{"add_minmin", 64'h8000000000000000, 64'h8000000000000000,
                 2'b00, 65'h1_0000000000000000};
    vecs[4]  = '{"sub_100_64", 64'd100, 64'd64, 2'b01, 65'd36};
    vecs[5]  = '{"sub_0_1",    64'd0, 64'd1, 2'b01, 65'h0_FFFFFFFFFFFFFFFF};
    vecs[6]  = '{"sub_min_1",  64'h8000000000000000, 64'd1, 2'b01,
                 65'h1_7FFFFFFFFFFFFFFF};
    vecs[7]  = '{"sub_5_5",    64'd5, 64'd5, 2'b01, 65'h0};
    vecs[8]  = '{"and_f0f0",   64'hF0F0, 64'hFF00, 2'b10, 65'hF000};
    vecs[9]  = '{"xor_ff_0f",  64'hFF, 64'h0F, 2'b11, 65'hF0};
    vecs[10] = '{"xor_self",   64'hDEADBEEF12345678, 64'hDEADBEEF12345678,
                 2'b11, 65'h0};
    vecs[11] = '{"and_ones",   64'h123456789ABCDEF0, 64'hFFFFFFFFFFFFFFFF,
                 2'b10, 65'h0_123456789ABCDEF0};
    vecs[12] = '{"sub_neg_pos", 64'h8000000000000005, 64'h10, 2'b01,
                 65'h1_7FFFFFFFFFFFFFF5};

    // Reset held across three edges
    rst_n = 1'b0;
    drive(64'd5, 64'd7, 2'b00);
    #1;
    check("reset_async", bus.Final_Output, 65'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", bus.Final_Output, 65'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", bus.Final_Output, 65'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midcycle", bus.Final_Output, 65'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].s);
      @(posedge clk);
      #1;
      check(vecs[i].name, bus.Final_Output, vecs[i].exp);
    end

    // Back-to-back select changes
    bb_exp[0] = 65'd7;
    bb_exp[1] = 65'h0_FFFFFFFFFFFFFFFF;
    bb_exp[2] = 65'd2;
    bb_exp[3] = 65'd5;
    drive(64'd3, 64'd4, 2'b00);
    @(posedge clk);
    #1;
    check("b2b_add", bus.Final_Output, bb_exp[0]);
    drive(64'd3, 64'd4, 2'b01);
    @(posedge clk);
    #1;
    check("b2b_sub", bus.Final_Output, bb_exp[1]);
    drive(64'd6, 64'd3, 2'b10);
    @(posedge clk);
    #1;
    check("b2b_and", bus.Final_Output, bb_exp[2]);
    drive(64'd6, 64'd3, 2'b11);
    @(posedge clk);
    #1;
    check("b2b_xor", bus.Final_Output, bb_exp[3]);

    // Output must hold while inputs toggle between edges
    held = bus.Final_Output;
    drive(64'hAAAA, 64'h5555, 2'b00);
    #2;
    drive(64'h1, 64'h2, 2'b01);
    #2;
    check("hold_between_edges", bus.Final_Output, bb_exp[3]);
    @(posedge clk);
    #1;
    check("after_toggle", bus.Final_Output,
          65'h0_FFFFFFFFFFFFFFFF);

    // Random vectors
    for (int k = 0; k < 10000; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 2'($urandom_range(3, 0));
      if (k % 8 == 0) rb[63] = ra[63];
      drive(ra, rb, rs);
      @(posedge clk);
      #1;
      check("random", bus.Final_Output, model(ra, rb, rs));
    end

    if (held !== bb_exp[3]) begin
      n_chk++;
      n_fail++;
      $display("FAIL held_snapshot: got %h expected %h", held, bb_exp[3]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
